// File: rtl/fp32_mult_seq_if.sv
// Request/response bundle between the peripherals unit and the FP32 multiplier.
// master drives operands and start; slave returns status and result.
interface fp32_mult_seq_if;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] dataR;
    logic [4:0]  casesspecial;

    modport master (
        output start, dataA, dataB,
        input  busy, done, dataR, casesspecial
    );

    modport slave (
        input  start, dataA, dataB,
        output busy, done, dataR, casesspecial
    );
endinterface

// File: rtl/fp32_mult_seq.sv
// Sequential IEEE-754 single-precision multiplier with a shift-add mantissa core.
// Truncating (round toward zero), denormal inputs flushed to zero, no denormal outputs.
module fp32_mult_seq #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    fp32_mult_seq_if.slave    bus
);

    localparam int unsigned ITER = 24 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MULT,
        NORM,
        PACK
    } state_t;

    state_t state, state_n;

    logic [31:0] a_reg, b_reg;
    logic [23:0] ma, mb;
    logic [47:0] product;
    logic [4:0]  cnt;
    logic [4:0]  shift;
    logic [31:0] res_reg;
    logic [4:0]  flag_reg;
    logic [31:0] result_q;
    logic [4:0]  flags_q;
    logic        done_q;

    // Operand fields and classification from the captured operands
    logic       sa, sb, sign;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_special;
    logic [31:0] spec_res;
    logic [4:0]  spec_flags;

    always_comb begin
        sa     = a_reg[31];
        sb     = b_reg[31];
        ea     = a_reg[30:23];
        eb     = b_reg[30:23];
        fa     = a_reg[22:0];
        fb     = b_reg[22:0];
        sign   = sa ^ sb;
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (fa == '0);
        b_inf  = (eb == 8'hFF) && (fb == '0);
        a_nan  = (ea == 8'hFF) && (fa != '0);
        b_nan  = (eb == 8'hFF) && (fb != '0);
        is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    end

    always_comb begin
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_res   = 32'h7FC0_0000;
            spec_flags = 5'b00100;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_res   = 32'h7FC0_0000;
            spec_flags = 5'b00100;
        end else if (a_inf || b_inf) begin
            spec_res   = {sign, 8'hFF, 23'h0};
            spec_flags = 5'b00010;
        end else if (a_zero || b_zero) begin
            spec_res   = {sign, 31'h0};
            spec_flags = 5'b00001;
        end
    end

    // Partial product for the next BITS_PER_CYCLE multiplier bits
    logic [47:0] pp;

    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mb[i]) begin
                pp = pp + ({24'h0, ma} << i);
            end
        end
    end

    logic signed [9:0] exp_n;
    logic [22:0]       mant;
    logic [31:0]       norm_res;
    logic [4:0]        norm_flags;

    always_comb begin
        exp_n = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (product[47]) begin
            exp_n = exp_n + 10'sd1;
        end
        mant = 23'(product[47] ? (product >> 24) : (product >> 23));
        if (exp_n >= 10'sd255) begin
            norm_res   = {sign, 8'hFF, 23'h0};
            norm_flags = 5'b01010;
        end else if (exp_n <= 10'sd0) begin
            norm_res   = {sign, 31'h0};
            norm_flags = 5'b10000;
        end else begin
            norm_res   = {sign, exp_n[7:0], mant};
            norm_flags = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = UNPACK;
            UNPACK:  state_n = is_special ? PACK : MULT;
            MULT:    if (cnt == '0) state_n = NORM;
            NORM:    state_n = PACK;
            PACK:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            ma       <= '0;
            mb       <= '0;
            product  <= '0;
            cnt      <= '0;
            shift    <= '0;
            res_reg  <= '0;
            flag_reg <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.dataA;
                        b_reg <= bus.dataB;
                    end
                end
                UNPACK: begin
                    if (is_special) begin
                        res_reg  <= spec_res;
                        flag_reg <= spec_flags;
                    end else begin
                        product <= '0;
                        ma      <= {1'b1, fa};
                        mb      <= {1'b1, fb};
                        cnt     <= 5'(ITER - 1);
                        shift   <= '0;
                    end
                end
                MULT: begin
                    // mb shifts down so the low bits are always the next chunk; shift tracks its weight
                    product <= product + (pp << shift);
                    mb      <= mb >> BITS_PER_CYCLE;
                    shift   <= shift + 5'(BITS_PER_CYCLE);
                    cnt     <= cnt - 5'd1;
                end
                NORM: begin
                    res_reg  <= norm_res;
                    flag_reg <= norm_flags;
                end
                PACK: begin
                    result_q <= res_reg;
                    flags_q  <= flag_reg;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_q;
    assign bus.dataR        = result_q;
    assign bus.casesspecial = flags_q;

endmodule

// File: tb/tb_fp32_mult_seq.sv
// Scoreboard bench for fp32_mult_seq: driver pushes model results, monitor pops on done.
module tb_fp32_mult_seq;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    fp32_mult_seq_if bus ();

    fp32_mult_seq #(.BITS_PER_CYCLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] r;
        logic [4:0]  f;
        int          c;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference built from the IEEE field rules with integer arithmetic
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f, output int lat);
        int          ea, eb, e;
        longint      fa, fb, p, m;
        bit          s, an, bn, ai, bi, az, bz;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        s  = a[31] ^ b[31];
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        az = (ea == 0);
        bz = (eb == 0);
        lat = 2;
        if (an || bn)                      begin r = 32'h7FC00000; f = 5'b00100; end
        else if ((ai && bz) || (bi && az)) begin r = 32'h7FC00000; f = 5'b00100; end
        else if (ai || bi)                 begin r = {s, 8'hFF, 23'h0}; f = 5'b00010; end
        else if (az || bz)                 begin r = {s, 31'h0}; f = 5'b00001; end
        else begin
            lat = 27;
            p = (fa + 64'd8388608) * (fb + 64'd8388608);
            e = ea + eb - 127;
            if (p >= 64'h8000_0000_0000) begin
                m = (p / 64'd16777216) % 64'd8388608;
                e = e + 1;
            end else begin
                m = (p / 64'd8388608) % 64'd8388608;
            end
            if (e >= 255)    begin r = {s, 8'hFF, 23'h0}; f = 5'b01010; end
            else if (e <= 0) begin r = {s, 31'h0}; f = 5'b10000; end
            else             begin r = {s, 8'(e), 23'(m)}; f = 5'b00000; end
        end
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
        end
    endtask

    // Issue one op at a negedge; the following posedge is the sampling edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        model(a, b, e.r, e.f, e.lat);
        e.c = cyc + 1;
        sb_q.push_back(e);
        bus.dataA = a;
        bus.dataB = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=%h required=no_done (cycle %0d)", bus.dataR, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("dataR", bus.dataR, e.r);
                chk("casesspecial", 32'(bus.casesspecial), 32'(e.f));
                chk("latency", 32'(cyc - e.c), 32'(e.lat));
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    logic [31:0] pool [10] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                               32'h7FC00000, 32'h7F800001, 32'h00400000, 32'h3F800000,
                               32'h7F7FFFFF, 32'h00800000};

    initial begin
        logic [31:0] a, b;
        int n;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.dataA = '0;
        bus.dataB = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_dataR", bus.dataR, 32'h0);
        chk("reset_flags", 32'(bus.casesspecial), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);

        issue(32'h40000000, 32'h40400000);
        issue(32'h3FC00000, 32'h3FC00000);
        issue(32'h7F800000, 32'h00000000);
        issue(32'hFF800000, 32'h40000000);
        issue(32'h7F000000, 32'h40000000);
        issue(32'h00800000, 32'h00800000);
        issue(32'h3F800000, 32'h00400000);
        issue(32'hBF800000, 32'h3F800000);

        // Extra start pulse while busy must be ignored
        issue(32'h40000000, 32'h40400000);
        repeat (4) @(negedge clk);
        bus.dataA = 32'h3F800000;
        bus.dataB = 32'h3F800000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Reset mid-operation aborts with no done
        issue(32'h3FC00000, 32'h40400000);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("midreset_dataR", bus.dataR, 32'h0);
        chk("midreset_flags", 32'(bus.casesspecial), 32'h0);
        chk("midreset_busy", 32'(bus.busy), 32'h0);
        chk("midreset_done", 32'(bus.done), 32'h0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        issue(32'h40400000, 32'h40400000);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1, 2: begin
                    a = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
                    b = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
                end
                default: begin
                    a = pool[$urandom_range(0, 9)];
                    b = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 9)] : 32'($urandom);
                end
            endcase
            if ($urandom_range(0, 1) == 1) begin
                issue(a, b);
            end else begin
                issue(b, a);
            end
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0 pending results", sb_q.size());
        end
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
